// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch with wrapping PC, redirect, variable-latency
//            memory requests and a FIFO fetch queue feeding decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int INSTR_W    = 32,
    parameter int ADDR_W     = 10,
    parameter int NUM_INSTRS = 1024,
    parameter int FQ_DEPTH   = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic               sys_clock,
    input  logic               reset_n,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               id_ready,
    output logic [ADDR_W-1:0]  fetch_pc
);

    localparam int c_PTR_W = $clog2(FQ_DEPTH);
    // Wide enough to hold queued + in-flight without overflow
    localparam int c_CNT_W = $clog2(FQ_DEPTH) + 2;
    localparam logic [c_CNT_W-1:0] c_FQ_DEPTH    = c_CNT_W'(FQ_DEPTH);
    localparam logic [c_CNT_W-1:0] c_MAX_OUTST   = c_CNT_W'(MAX_OUTST);
    localparam logic [ADDR_W:0]    c_NUM_INSTRS  = (ADDR_W+1)'(NUM_INSTRS);
    localparam logic [ADDR_W:0]    c_ONE         = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0]  r_resp_pc;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_outst;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [INSTR_W-1:0] r_q_instr [FQ_DEPTH];
    logic [ADDR_W-1:0]  r_q_pc    [FQ_DEPTH];

    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_outst_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [ADDR_W-1:0]  w_redirect_pc;

    function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] x);
        logic [ADDR_W:0] v;
        v = {1'b0, x} + c_ONE;
        return (v == c_NUM_INSTRS) ? '0 : v[ADDR_W-1:0];
    endfunction

    assign w_redirect_pc  = ({1'b0, redirect_pc} >= c_NUM_INSTRS) ? '0 : redirect_pc;

    assign imem_req_valid = reset_n & ~redirect_valid & (r_outst < c_MAX_OUTST)
                          & ((r_count + r_outst) < c_FQ_DEPTH);
    assign imem_req_addr  = fetch_pc;
    assign id_valid       = (r_count != '0);

    assign w_issue      = imem_req_valid & imem_req_ready;
    assign w_push       = imem_rsp_valid & ~redirect_valid & (r_drop_cnt == '0);
    assign w_pop        = id_valid & id_ready & ~redirect_valid;
    assign w_outst_nxt  = r_outst + c_CNT_W'(w_issue) - c_CNT_W'(imem_rsp_valid);
    assign w_count_nxt  = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_wr_ptr_nxt = r_wr_ptr + c_PTR_W'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(w_pop);

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc   <= '0;
            r_resp_pc  <= '0;
            r_outst    <= '0;
            r_drop_cnt <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight belongs to the old path
            fetch_pc   <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_outst    <= w_outst_nxt;
            r_drop_cnt <= w_outst_nxt;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_issue) begin
                fetch_pc <= f_inc(fetch_pc);
            end
            if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
            end
            if (w_push) begin
                r_resp_pc <= f_inc(r_resp_pc);
            end
            r_outst  <= w_outst_nxt;
            r_count  <= w_count_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rsp_data;
            r_q_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

    // Head register: a push into an otherwise-empty queue bypasses the array
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            id_instr <= '0;
            id_pc    <= '0;
        end else if (!redirect_valid && (w_count_nxt != '0)) begin
            if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
                id_instr <= imem_rsp_data;
                id_pc    <= r_resp_pc;
            end else begin
                id_instr <= r_q_instr[w_rd_ptr_nxt];
                id_pc    <= r_q_pc[w_rd_ptr_nxt];
            end
        end
    end

    a_no_overflow: assert property (@(posedge sys_clock) disable iff (!reset_n)
                                    !(w_push && !w_pop && (r_count == c_FQ_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: queue-based reference model,
//            in-order variable-latency memory model, directed and random runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int INSTR_W    = 32;
    localparam int ADDR_W     = 8;
    localparam int NUM_INSTRS = 100;
    localparam int FQ_DEPTH   = 4;
    localparam int MAX_OUTST  = 4;

    logic               sys_clock = 1'b0;
    logic               reset_n   = 1'b0;
    logic               redirect_valid = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc    = '0;
    logic               imem_req_valid;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_req_ready = 1'b0;
    logic               imem_rsp_valid = 1'b0;
    logic [INSTR_W-1:0] imem_rsp_data  = '0;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic               id_ready = 1'b0;
    logic [ADDR_W-1:0]  fetch_pc;

    fetch_unit #(
        .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NUM_INSTRS(NUM_INSTRS),
        .FQ_DEPTH(FQ_DEPTH), .MAX_OUTST(MAX_OUTST)
    ) u_dut (
        .sys_clock(sys_clock), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_ready(id_ready), .fetch_pc(fetch_pc)
    );

    always #5 sys_clock = ~sys_clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    typedef struct { logic [ADDR_W-1:0] addr; int due; } req_t;
    typedef struct { logic [ADDR_W-1:0] pc; logic [INSTR_W-1:0] instr; } ent_t;
    typedef struct {
        logic rq_rdy; logic id_rdy;
        logic exp_rv; logic [ADDR_W-1:0] exp_addr;
        logic exp_idv; logic [ADDR_W-1:0] exp_pc;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, lat = 2, last_due = -1, n_issue = 0;
    req_t pend[$];
    ent_t m_q[$];
    ent_t m_last;
    int   m_fetch, m_resp, m_outst, m_drop;
    logic s_rv, s_idv;
    logic [ADDR_W-1:0] s_addr, s_pc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'hC0DE_0000 ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    function automatic int inc_pc(input int x);
        return (x + 1 == NUM_INSTRS) ? 0 : x + 1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        pend.delete();
        m_last   = '{pc: '0, instr: '0};
        m_fetch  = 0; m_resp = 0; m_outst = 0; m_drop = 0;
        last_due = -1;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance both.
    task automatic run_cycle(input logic redir, input logic [ADDR_W-1:0] rpc,
                             input logic rq_rdy, input logic idr);
        logic rsp, exp_rv, issue_m;
        int   due;
        ent_t e;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rq_rdy;
        id_ready       = idr;
        rsp            = (pend.size() != 0) && (pend[0].due == cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(pend[0].addr) : INSTR_W'($urandom);
        #1;
        exp_rv = !redir && (m_outst < MAX_OUTST) && (m_q.size() + m_outst < FQ_DEPTH);
        if (m_q.size() != 0) m_last = m_q[0];
        chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        if (exp_rv) chk("req_addr", 64'(imem_req_addr), 64'(m_fetch));
        chk("fetch_pc", 64'(fetch_pc), 64'(m_fetch));
        chk("id_valid", 64'(id_valid), 64'(m_q.size() != 0));
        chk("id_pc", 64'(id_pc), 64'(m_last.pc));
        chk("id_instr", 64'(id_instr), 64'(m_last.instr));
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_idv = id_valid; s_pc = id_pc;
        if (imem_req_valid && imem_req_ready) begin
            n_issue++;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            pend.push_back('{addr: imem_req_addr, due: due});
            last_due = due;
        end
        if (rsp) void'(pend.pop_front());
        issue_m = exp_rv && rq_rdy;
        if (redir) begin
            m_q.delete();
            m_fetch = (int'(rpc) >= NUM_INSTRS) ? 0 : int'(rpc);
            m_resp  = m_fetch;
            m_outst = m_outst - int'(rsp);
            m_drop  = m_outst;
        end else begin
            if (m_q.size() != 0 && idr) void'(m_q.pop_front());
            if (rsp) begin
                if (m_drop > 0) m_drop--;
                else begin
                    e.pc = ADDR_W'(m_resp); e.instr = imem_rsp_data;
                    m_q.push_back(e);
                    m_resp = inc_pc(m_resp);
                end
            end
            if (issue_m) m_fetch = inc_pc(m_fetch);
            m_outst = m_outst + int'(issue_m) - int'(rsp);
        end
        @(posedge sys_clock); #1;
        cyc++;
    endtask

    task automatic async_reset();
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_fetch_pc", 64'(fetch_pc), 64'd0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_id_pc", 64'(id_pc), 64'd0);
        chk("rst_id_instr", 64'(id_instr), 64'd0);
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        model_reset();
        @(posedge sys_clock); @(posedge sys_clock); #1;
        reset_n = 1'b1;
    endtask

    vec_t tbl[10];
    int   stall_base, seen, pcs[$];
    logic found;

    initial begin
        // Reset release: L=2, always ready; then a two-cycle decode stall
        tbl[0] = '{1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 8'd3, 1'b1, 8'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 8'd4, 1'b1, 8'd1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 8'd2};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 8'd6, 1'b1, 8'd3};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 8'd7, 1'b1, 8'd4};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 8'd8, 1'b1, 8'd5};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd5};

        model_reset();
        #1;
        chk("por_id_valid", 64'(id_valid), 64'd0);
        chk("por_req_valid", 64'(imem_req_valid), 64'd0);
        @(posedge sys_clock); @(posedge sys_clock); #1;
        reset_n = 1'b1;

        stall_base = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) stall_base = n_issue;
            run_cycle(1'b0, '0, tbl[i].rq_rdy, tbl[i].id_rdy);
            chk($sformatf("tbl%0d_req_valid", i), 64'(s_rv), 64'(tbl[i].exp_rv));
            if (tbl[i].exp_rv) chk($sformatf("tbl%0d_req_addr", i), 64'(s_addr), 64'(tbl[i].exp_addr));
            chk($sformatf("tbl%0d_id_valid", i), 64'(s_idv), 64'(tbl[i].exp_idv));
            if (tbl[i].exp_idv) chk($sformatf("tbl%0d_id_pc", i), 64'(s_pc), 64'(tbl[i].exp_pc));
        end

        // Remaining stall cycles: issue must stop at the credit limit
        for (int i = 0; i < 8; i++) run_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("stall_issues_le_depth", 64'(n_issue - stall_base <= FQ_DEPTH), 64'd1);
        chk("stall_req_valid_low", 64'(s_rv), 64'd0);
        // Drain: four entries in four cycles, no refill
        for (int k = 0; k < 4; k++) begin
            run_cycle(1'b0, '0, 1'b0, 1'b1);
            chk("drain_valid", 64'(s_idv), 64'd1);
            chk("drain_pc", 64'(s_pc), 64'(5 + k));
        end
        run_cycle(1'b0, '0, 1'b0, 1'b1);
        chk("drain_empty", 64'(s_idv), 64'd0);

        // Redirect to 0x40 with one queued entry and three in flight
        lat = 1;
        run_cycle(1'b0, '0, 1'b1, 1'b0);
        lat = 8;
        for (int i = 0; i < 3; i++) run_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("pre_redir_queued", 64'(id_valid), 64'd1);
        chk("pre_redir_credit_block", 64'(imem_req_valid), 64'd0);
        run_cycle(1'b1, 8'h40, 1'b1, 1'b0);
        lat = 2;
        run_cycle(1'b0, '0, 1'b1, 1'b1);
        chk("redir_flush_t1", 64'(s_idv), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b1);
            if (s_idv) begin
                found = 1'b1;
                chk("redir_first_pc", 64'(s_pc), 64'h40);
            end
        end
        chk("redir_first_valid_seen", 64'(found), 64'd1);

        // Redirect coinciding with a response, to an out-of-range PC
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend.size() != 0 && pend[0].due == cyc) found = 1'b1;
            else run_cycle(1'b0, '0, 1'b1, 1'b1);
        end
        chk("samecyc_rsp_found", 64'(found), 64'd1);
        run_cycle(1'b1, 8'(NUM_INSTRS + 3), 1'b1, 1'b1);
        chk("samecyc_fetch_pc_zero", 64'(fetch_pc), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b1);
            if (s_idv) begin
                found = 1'b1;
                chk("samecyc_first_pc", 64'(s_pc), 64'd0);
            end
        end
        chk("samecyc_valid_seen", 64'(found), 64'd1);

        // Wrap-around past the last instruction
        lat = 2;
        run_cycle(1'b1, 8'(NUM_INSTRS - 3), 1'b1, 1'b1);
        pcs.delete();
        for (int i = 0; i < 15; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b1);
            if (s_idv) pcs.push_back(int'(s_pc));
        end
        chk("wrap_count", 64'(pcs.size() >= 5), 64'd1);
        if (pcs.size() >= 5) begin
            chk("wrap_pc0", 64'(pcs[0]), 64'(NUM_INSTRS - 3));
            chk("wrap_pc2", 64'(pcs[2]), 64'(NUM_INSTRS - 1));
            chk("wrap_pc3", 64'(pcs[3]), 64'd0);
            chk("wrap_pc4", 64'(pcs[4]), 64'd1);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 2000; i++) begin
            lat = $urandom_range(1, 5);
            run_cycle(($urandom_range(0, 99) < 3), 8'($urandom_range(0, 255)),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
        end

        // Asynchronous reset with a full queue
        lat = 1;
        for (int i = 0; i < 8; i++) run_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("full_before_reset", 64'(id_valid), 64'd1);
        async_reset();
        seen = -1;
        lat = 2;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, '0, 1'b1, 1'b1);
            if (s_idv && seen < 0) seen = i;
        end
        chk("post_reset_first_valid_cycle", 64'(seen), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
